// File: rtl/mips_harvard_mem_pkg.sv
// Shared types and address decode for the Harvard memory subsystem.
package mips_harvard_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        GRANT = 2'd2
    } state_e;

    localparam logic [31:0] ROM_BASE_DEF = 32'hBFC0_0000;
    localparam logic [31:0] RAM_BASE_DEF = 32'h0000_0000;

    typedef struct packed {
        logic        hit;
        logic [31:0] idx;
    } decode_t;

    // Unsigned offset compare also rejects addresses below base (they wrap high).
    function automatic decode_t decode_addr(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input logic [31:0] words);
        logic [31:0] off;
        decode_t     d;
        off   = addr - base;
        d.hit = (off < (words << 2)) && (addr[1:0] == 2'b00);
        d.idx = off >> 2;
        return d;
    endfunction

endpackage

// File: rtl/mips_harvard_wait_fsm.sv
// Wait-state sequencer: stalls the CPU for WAIT_STATES cycles per data access.
//   state | meaning
//   IDLE  | no access in flight; a valid request stalls here for its first cycle
//   WAIT  | remaining stall cycles, cnt counts down to terminal count
//   GRANT | CPU advances for one cycle; a pending write commits on this edge
module mips_harvard_wait_fsm
    import mips_harvard_mem_pkg::*;
#(
    parameter int WAIT_STATES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic valid_i,
    output logic clk_enable_o,
    output logic commit_o
);

    localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_e     state_q;
    logic [3:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_i && (WAIT_STATES > 0)) begin
                        cnt_q   <= CNT_LOAD;
                        state_q <= (WAIT_STATES > 1) ? WAIT : GRANT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_q <= GRANT;
                    end
                end
                GRANT:   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Stall must drop in the same cycle the request appears, so this decode is combinational.
    always_comb begin
        clk_enable_o = 1'b1;
        commit_o     = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (WAIT_STATES == 0) begin
                        commit_o = valid_i;
                    end else begin
                        clk_enable_o = ~valid_i;
                    end
                end
                WAIT:    clk_enable_o = 1'b0;
                GRANT:   commit_o = 1'b1;
                default: clk_enable_o = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/mips_harvard_mem.sv
// Instruction ROM and data RAM behind the Harvard CPU buses, with wait-state stalls,
// sticky error flags and a committed-write counter.
module mips_harvard_mem
    import mips_harvard_mem_pkg::*;
#(
    parameter logic [31:0] ROM_BASE      = ROM_BASE_DEF,
    parameter int          ROM_WORDS     = 256,
    parameter logic [31:0] RAM_BASE      = RAM_BASE_DEF,
    parameter int          RAM_WORDS     = 256,
    parameter int          WAIT_STATES   = 2,
    parameter string       ROM_INIT_FILE = "",
    parameter string       RAM_INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    input  logic [31:0] data_address,
    input  logic        data_write,
    input  logic        data_read,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    output logic        clk_enable,
    output logic        err_instr,
    output logic        err_data,
    output logic [31:0] write_count
);

    localparam int ROM_AW = (ROM_WORDS > 1) ? $clog2(ROM_WORDS) : 1;
    localparam int RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

    logic [31:0] rom_mem [ROM_WORDS] = '{default: 32'h0};
    logic [31:0] ram_q   [RAM_WORDS] = '{default: 32'h0};

    decode_t           rom_dec;
    decode_t           ram_dec;
    logic [ROM_AW-1:0] rom_idx;
    logic [RAM_AW-1:0] ram_idx;
    logic              unused_idx_bits;

    assign rom_dec = decode_addr(instr_address, ROM_BASE, 32'(ROM_WORDS));
    assign ram_dec = decode_addr(data_address, RAM_BASE, 32'(RAM_WORDS));
    assign rom_idx = rom_dec.idx[ROM_AW-1:0];
    assign ram_idx = ram_dec.idx[RAM_AW-1:0];
    assign unused_idx_bits = ^{rom_dec.idx[31:ROM_AW], ram_dec.idx[31:RAM_AW]};

    logic req_any;
    logic data_valid;
    logic commit;
    logic wr_commit;

    assign req_any    = data_read | data_write;
    assign data_valid = (data_read ^ data_write) & ram_dec.hit;

    assign instr_readdata = rom_dec.hit ? rom_mem[rom_idx] : 32'h0;
    assign data_readdata  = (data_valid && data_read) ? ram_q[ram_idx] : 32'h0;

    mips_harvard_wait_fsm #(
        .WAIT_STATES(WAIT_STATES)
    ) u_wait_fsm (
        .clk         (clk),
        .reset       (reset),
        .valid_i     (data_valid),
        .clk_enable_o(clk_enable),
        .commit_o    (commit)
    );

    // A request dropped mid-stall still reaches GRANT but only writes if still asserted.
    assign wr_commit = commit & data_valid & data_write;

    always_ff @(posedge clk) begin
        if (wr_commit) begin
            ram_q[ram_idx] <= data_writedata;
        end
    end

    logic        err_instr_q, err_instr_d;
    logic        err_data_q,  err_data_d;
    logic [31:0] write_count_q, write_count_d;

    always_comb begin
        err_instr_d   = err_instr_q | ~rom_dec.hit;
        err_data_d    = err_data_q | (req_any & ~data_valid);
        write_count_d = wr_commit ? (write_count_q + 32'd1) : write_count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_instr_q   <= 1'b0;
            err_data_q    <= 1'b0;
            write_count_q <= 32'd0;
        end else begin
            err_instr_q   <= err_instr_d;
            err_data_q    <= err_data_d;
            write_count_q <= write_count_d;
        end
    end

    assign err_instr   = err_instr_q;
    assign err_data    = err_data_q;
    assign write_count = write_count_q;

endmodule

// File: tb/tb_mips_harvard_mem.sv
// Directed bench: one instance with two wait states, one with none.
module tb_mips_harvard_mem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] a_iaddr, a_irdata, a_daddr, a_wdata, a_rdata, a_wcount;
    logic        a_wr, a_rd, a_ce, a_ei, a_ed;
    logic [31:0] b_iaddr, b_irdata, b_daddr, b_wdata, b_rdata, b_wcount;
    logic        b_wr, b_rd, b_ce, b_ei, b_ed;

    int checks   = 0;
    int failures = 0;

    mips_harvard_mem #(.WAIT_STATES(2)) dut_a (
        .clk(clk), .reset(reset),
        .instr_address(a_iaddr), .instr_readdata(a_irdata),
        .data_address(a_daddr), .data_write(a_wr), .data_read(a_rd),
        .data_writedata(a_wdata), .data_readdata(a_rdata),
        .clk_enable(a_ce), .err_instr(a_ei), .err_data(a_ed),
        .write_count(a_wcount)
    );

    mips_harvard_mem #(.WAIT_STATES(0)) dut_b (
        .clk(clk), .reset(reset),
        .instr_address(b_iaddr), .instr_readdata(b_irdata),
        .data_address(b_daddr), .data_write(b_wr), .data_read(b_rd),
        .data_writedata(b_wdata), .data_readdata(b_rdata),
        .clk_enable(b_ce), .err_instr(b_ei), .err_data(b_ed),
        .write_count(b_wcount)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives a request at a negedge and counts stalled cycles until clk_enable rises.
    task automatic a_xfer(input logic [31:0] addr, input logic wr, input logic rd,
                          input logic [31:0] wd, output int stalls, output logic [31:0] rdata);
        stalls = 0;
        @(negedge clk);
        a_daddr = addr; a_wr = wr; a_rd = rd; a_wdata = wd;
        #1;
        while (a_ce !== 1'b1 && stalls < 20) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        rdata = a_rdata;
    endtask

    task automatic a_idle();
        @(negedge clk);
        a_wr = 1'b0; a_rd = 1'b0;
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    int          st;
    logic [31:0] rd;

    initial begin
        reset = 1'b1;
        a_iaddr = 32'hBFC0_0000; a_daddr = 32'h4; a_wr = 1'b0; a_rd = 1'b1; a_wdata = '0;
        b_iaddr = 32'hBFC0_0000; b_daddr = 32'h0; b_wr = 1'b0; b_rd = 1'b0; b_wdata = '0;
        dut_a.rom_mem[0]   = 32'h3C08_BFC0;
        dut_a.rom_mem[255] = 32'h1000_FFFF;

        // reset with a pending read: stall must be suppressed
        repeat (2) @(negedge clk);
        #1;
        check("rst_ce", 32'(a_ce), 32'd1);
        check("rst_wcount", a_wcount, 32'd0);
        check("rst_err", {30'd0, a_ei, a_ed}, 32'd0);
        @(negedge clk);
        reset = 1'b0; a_rd = 1'b0;

        a_xfer(32'h4, 1'b1, 1'b0, 32'hDEAD_BEEF, st, rd);
        check("wr4_stalls", st, 32'd2);
        a_xfer(32'h4, 1'b0, 1'b1, 32'h0, st, rd);
        check("rd4_stalls", st, 32'd2);
        check("rd4_data", rd, 32'hDEAD_BEEF);
        a_idle();
        check("after_grant_ce", 32'(a_ce), 32'd1);
        check("wcount_1", a_wcount, 32'd1);

        a_xfer(32'h8, 1'b1, 1'b0, 32'h1234_5678, st, rd);
        check("wr8_stalls", st, 32'd2);
        check("ram2_pre_grant", dut_a.ram_q[2], 32'h0);
        a_idle();
        check("ram2_post_grant", dut_a.ram_q[2], 32'h1234_5678);
        check("wcount_2", a_wcount, 32'd2);
        a_xfer(32'h8, 1'b0, 1'b1, 32'h0, st, rd);
        check("rd8_data", rd, 32'h1234_5678);
        a_idle();

        @(negedge clk); a_iaddr = 32'hBFC0_0000; #1;
        check("fetch_rom0", a_irdata, 32'h3C08_BFC0);
        @(negedge clk); a_iaddr = 32'hBFC0_03FC; #1;
        check("fetch_rom255", a_irdata, 32'h1000_FFFF);
        check("err_instr_clear", 32'(a_ei), 32'd0);
        @(negedge clk); a_iaddr = 32'hBFC0_0400; #1;
        check("fetch_past_end", a_irdata, 32'h0);
        @(negedge clk); a_iaddr = 32'hBFC0_0000; #1;
        check("err_instr_end", 32'(a_ei), 32'd1);

        @(negedge clk); a_daddr = 32'h400; a_wr = 1'b1; a_wdata = 32'hCAFE_F00D; #1;
        check("unmapped_wr_ce", 32'(a_ce), 32'd1);
        @(negedge clk); a_wr = 1'b0; #1;
        check("unmapped_wr_err", 32'(a_ed), 32'd1);
        check("unmapped_wr_wcount", a_wcount, 32'd2);
        check("unmapped_wr_ram0", dut_a.ram_q[0], 32'h0);

        // reset lands while a write sits in WAIT
        @(negedge clk); a_daddr = 32'hC; a_wr = 1'b1; a_wdata = 32'hAAAA_5555; #1;
        check("midrst_stall", 32'(a_ce), 32'd0);
        @(negedge clk);
        reset = 1'b1; #1;
        check("midrst_ce_forced", 32'(a_ce), 32'd1);
        @(negedge clk);
        reset = 1'b0; a_wr = 1'b0; #1;
        check("midrst_ram3", dut_a.ram_q[3], 32'h0);
        check("midrst_wcount", a_wcount, 32'd0);
        check("midrst_err", {30'd0, a_ei, a_ed}, 32'd0);
        check("midrst_ce_idle", 32'(a_ce), 32'd1);
        a_xfer(32'h4, 1'b0, 1'b1, 32'h0, st, rd);
        check("post_rst_stalls", st, 32'd2);
        check("post_rst_data", rd, 32'hDEAD_BEEF);
        a_idle();
        check("midrst_ram3_later", dut_a.ram_q[3], 32'h0);

        @(negedge clk); a_iaddr = 32'hBFC0_0002; #1;
        check("fetch_misaligned", a_irdata, 32'h0);
        @(negedge clk); a_iaddr = 32'hBFC0_0000; #1;
        check("err_instr_misal", 32'(a_ei), 32'd1);

        pulse_reset();
        @(negedge clk); a_daddr = 32'h1; a_rd = 1'b1; #1;
        check("misal_rd_ce", 32'(a_ce), 32'd1);
        check("misal_rd_data", a_rdata, 32'h0);
        @(negedge clk); a_rd = 1'b0; #1;
        check("misal_rd_err", 32'(a_ed), 32'd1);

        pulse_reset();
        @(negedge clk); a_daddr = 32'h4; a_rd = 1'b1; a_wr = 1'b1; a_wdata = 32'h0; #1;
        check("both_ce", 32'(a_ce), 32'd1);
        check("both_data", a_rdata, 32'h0);
        @(negedge clk); a_rd = 1'b0; a_wr = 1'b0; #1;
        check("both_err", 32'(a_ed), 32'd1);
        check("both_wcount", a_wcount, 32'd0);
        check("both_ram1", dut_a.ram_q[1], 32'hDEAD_BEEF);

        // zero wait states: single-cycle back-to-back writes
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            b_daddr = 32'(i * 4); b_wr = 1'b1; b_wdata = 32'h1111_0000 + 32'(i);
            #1;
            check("ws0_wr_ce", 32'(b_ce), 32'd1);
        end
        @(negedge clk); b_wr = 1'b0; #1;
        check("ws0_wcount", b_wcount, 32'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            b_daddr = 32'(i * 4); b_rd = 1'b1;
            #1;
            check("ws0_rd_ce", 32'(b_ce), 32'd1);
            check("ws0_rd_data", b_rdata, 32'h1111_0000 + 32'(i));
        end
        @(negedge clk); b_rd = 1'b0; #1;
        check("ws0_err", {30'd0, b_ei, b_ed}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
